// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, ALU function codes,
// opcode/func fields and the instruction classes produced by the decoder.
package multicycle_pkg;

  typedef enum logic [2:0] {
    ST_HALT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  localparam logic [2:0] ALU_IDLE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_AND = 4'b0100;
  localparam logic [3:0] FN_OR  = 4'b0101;
  localparam logic [3:0] FN_SLT = 4'b1010;

  typedef enum logic [2:0] {
    CLS_NONE    = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_ITYPE   = 3'd2,
    CLS_LOAD    = 3'd3,
    CLS_STORE   = 3'd4,
    CLS_JUMP    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } insn_class_t;

endpackage

// File: rtl/multicycle_ctrl_insn_class_decode.sv
// Combinational instruction classifier: maps op/func to an instruction class,
// the ALU function the datapath will need, and an illegal-encoding flag.
module insn_class_decode
  import multicycle_pkg::*;
(
  input  logic [5:0] op,
  input  logic [3:0] func,
  output logic [2:0] cls,
  output logic [2:0] alu_func,
  output logic       illegal
);

  always_comb begin
    cls      = CLS_ILLEGAL;
    alu_func = ALU_IDLE;
    case (op)
      OP_RTYPE: begin
        cls = CLS_RTYPE;
        case (func)
          FN_ADD:  alu_func = ALU_ADD;
          FN_SUB:  alu_func = ALU_SUB;
          FN_AND:  alu_func = ALU_AND;
          FN_OR:   alu_func = ALU_OR;
          FN_SLT:  alu_func = ALU_SLT;
          default: cls = CLS_ILLEGAL;
        endcase
      end
      OP_ADDI: begin cls = CLS_ITYPE; alu_func = ALU_ADD; end
      OP_ANDI: begin cls = CLS_ITYPE; alu_func = ALU_AND; end
      OP_ORI:  begin cls = CLS_ITYPE; alu_func = ALU_OR;  end
      OP_SLTI: begin cls = CLS_ITYPE; alu_func = ALU_SLT; end
      // Loads and stores use the ALU only for the base+offset address add.
      OP_LW:   begin cls = CLS_LOAD;  alu_func = ALU_ADD; end
      OP_SW:   begin cls = CLS_STORE; alu_func = ALU_ADD; end
      OP_J:    cls = CLS_JUMP;
      default: cls = CLS_ILLEGAL;
    endcase
    if (cls == CLS_ILLEGAL) alu_func = ALU_IDLE;
  end

  assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM (HALT/FETCH/DECODE/EXEC/MEM/WB/TRAP) for the datapath.
// Optional MULTICYCLE_CTRL_PERF_CNT_EN adds cycle_cnt and retired_cnt outputs.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter bit RESET_STATE_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] op,
  input  logic [3:0] func,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_sel_jump,
  output logic [2:0] alu_func,
  output logic       alu_src_imm,
  output logic       reg_we,
  output logic       reg_src_mem,
  output logic       halted,
  output logic       illegal
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retired_cnt
`endif
);

  state_t      state, state_nxt;
  insn_class_t cls_q;
  logic [2:0]  alu_q;

  logic [2:0]  dec_cls_raw;
  logic [2:0]  dec_alu;
  logic        dec_illegal;
  insn_class_t dec_cls;

  insn_class_decode u_decode (
    .op       (op),
    .func     (func),
    .cls      (dec_cls_raw),
    .alu_func (dec_alu),
    .illegal  (dec_illegal)
  );

  assign dec_cls = insn_class_t'(dec_cls_raw);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_STATE_HALT ? ST_HALT : ST_FETCH;
      cls_q <= CLS_NONE;
      alu_q <= ALU_IDLE;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) begin
        cls_q <= dec_cls;
        alu_q <= dec_alu;
      end
    end
  end

  // Jump completes in DECODE, so its PC write uses the live decode rather than cls_q.
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel_jump = 1'b0;
    alu_func    = ALU_IDLE;
    alu_src_imm = 1'b0;
    reg_we      = 1'b0;
    reg_src_mem = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;
    case (state)
      ST_HALT: begin
        halted = 1'b1;
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_cls == CLS_JUMP) begin
          pc_we       = 1'b1;
          pc_sel_jump = 1'b1;
          state_nxt   = ST_FETCH;
        end else if (dec_illegal) begin
          state_nxt = ST_TRAP;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_func    = alu_q;
        alu_src_imm = (cls_q != CLS_RTYPE);
        state_nxt   = (cls_q == CLS_LOAD || cls_q == CLS_STORE) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CLS_STORE);
        alu_func = ALU_ADD;
        if (dmem_ready) state_nxt = (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
      end
      ST_WB: begin
        reg_we      = 1'b1;
        reg_src_mem = (cls_q == CLS_LOAD);
        alu_func    = (cls_q == CLS_LOAD) ? ALU_IDLE : alu_q;
        state_nxt   = ST_FETCH;
      end
      ST_TRAP: begin
        halted  = 1'b1;
        illegal = 1'b1;
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic retire;

  assign retire = (state == ST_WB)
               || (state == ST_MEM && dmem_ready && cls_q == CLS_STORE)
               || (state == ST_DECODE && dec_cls == CLS_JUMP);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= 32'd0;
      retired_cnt <= 32'd0;
    end else begin
      if (state != ST_HALT && state != ST_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: walks each instruction class,
// memory wait states, traps, mid-instruction reset and the HALT-after-reset variant.
module tb_multicycle_ctrl;
  import multicycle_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] op;
  logic [3:0] func;
  logic       imem_ready;
  logic       dmem_ready;

  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel_jump;
  logic [2:0] alu_func;
  logic       alu_src_imm, reg_we, reg_src_mem, halted, illegal;

  logic       h_imem_req, h_dmem_req, h_dmem_we, h_ir_we, h_pc_we, h_pc_sel_jump;
  logic [2:0] h_alu_func;
  logic       h_alu_src_imm, h_reg_we, h_reg_src_mem, h_halted, h_illegal;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, retired_cnt, h_cycle_cnt, h_retired_cnt;
`endif

  int totalChecks = 0;
  int badChecks   = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .func(func),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel_jump(pc_sel_jump),
    .alu_func(alu_func), .alu_src_imm(alu_src_imm), .reg_we(reg_we),
    .reg_src_mem(reg_src_mem), .halted(halted), .illegal(illegal)
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
  );

  multicycle_ctrl #(.RESET_STATE_HALT(1'b1)) dut_h (
    .clk(clk), .rst(rst), .start(start), .op(op), .func(func),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(h_imem_req), .dmem_req(h_dmem_req), .dmem_we(h_dmem_we),
    .ir_we(h_ir_we), .pc_we(h_pc_we), .pc_sel_jump(h_pc_sel_jump),
    .alu_func(h_alu_func), .alu_src_imm(h_alu_src_imm), .reg_we(h_reg_we),
    .reg_src_mem(h_reg_src_mem), .halted(h_halted), .illegal(h_illegal)
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    , .cycle_cnt(h_cycle_cnt), .retired_cnt(h_retired_cnt)
`endif
  );

  logic [13:0] obs, obsH;
  assign obs  = {halted, illegal, imem_req, dmem_req, dmem_we, ir_we, pc_we,
                 pc_sel_jump, alu_src_imm, reg_we, reg_src_mem, alu_func};
  assign obsH = {h_halted, h_illegal, h_imem_req, h_dmem_req, h_dmem_we, h_ir_we, h_pc_we,
                 h_pc_sel_jump, h_alu_src_imm, h_reg_we, h_reg_src_mem, h_alu_func};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] mkVec(input logic h, input logic ill, input logic ireq,
                                        input logic dreq, input logic dwe, input logic irwe,
                                        input logic pcwe, input logic jsel, input logic imm,
                                        input logic rwe, input logic rmem, input logic [2:0] alu);
    return {h, ill, ireq, dreq, dwe, irwe, pcwe, jsel, imm, rwe, rmem, alu};
  endfunction

  task automatic checkOutput(input string tag, input logic [13:0] got, input logic [13:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] newOp, input logic [3:0] newFunc);
    op   = newOp;
    func = newFunc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected control vectors, bit order matches obs
  logic [13:0] vFetch, vFetchWait, vIdle, vJump, vHalt, vTrap;
  logic [13:0] vExecSub, vWbSub, vExecOri, vWbOri, vExecAddr, vMemLw, vMemSw, vWbLw;

  initial begin
    vFetch     = mkVec(0,0,1,0,0,1,1,0,0,0,0,3'b000);
    vFetchWait = mkVec(0,0,1,0,0,0,0,0,0,0,0,3'b000);
    vIdle      = mkVec(0,0,0,0,0,0,0,0,0,0,0,3'b000);
    vJump      = mkVec(0,0,0,0,0,0,1,1,0,0,0,3'b000);
    vHalt      = mkVec(1,0,0,0,0,0,0,0,0,0,0,3'b000);
    vTrap      = mkVec(1,1,0,0,0,0,0,0,0,0,0,3'b000);
    vExecSub   = mkVec(0,0,0,0,0,0,0,0,0,0,0,3'b010);
    vWbSub     = mkVec(0,0,0,0,0,0,0,0,0,1,0,3'b010);
    vExecOri   = mkVec(0,0,0,0,0,0,0,0,1,0,0,3'b100);
    vWbOri     = mkVec(0,0,0,0,0,0,0,0,0,1,0,3'b100);
    vExecAddr  = mkVec(0,0,0,0,0,0,0,0,1,0,0,3'b001);
    vMemLw     = mkVec(0,0,0,1,0,0,0,0,0,0,0,3'b001);
    vMemSw     = mkVec(0,0,0,1,1,0,0,0,0,0,0,3'b001);
    vWbLw      = mkVec(0,0,0,0,0,0,0,0,0,1,1,3'b000);

    rst = 1'b1; start = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    applyStimulus(OP_RTYPE, FN_SUB);
    tick();
    tick();
    checkOutput("reset_fetch", obs, vFetch);
    checkOutput("reset_halt", obsH, vHalt);
    rst = 1'b0;

    // sub: FETCH DECODE EXEC WB
    tick(); checkOutput("sub_decode", obs, vIdle);
    tick(); checkOutput("sub_exec", obs, vExecSub);
    tick(); checkOutput("sub_wb", obs, vWbSub);
    tick(); checkOutput("sub_next_fetch", obs, vFetch);

    // ori: immediate operand, OR function
    applyStimulus(OP_ORI, 4'b1111);
    tick(); checkOutput("ori_decode", obs, vIdle);
    tick(); checkOutput("ori_exec", obs, vExecOri);
    tick(); checkOutput("ori_wb", obs, vWbOri);
    tick(); checkOutput("ori_next_fetch", obs, vFetch);

    // lw with three data-memory wait cycles
    applyStimulus(OP_LW, FN_ADD);
    tick(); checkOutput("lw_decode", obs, vIdle);
    tick(); checkOutput("lw_exec", obs, vExecAddr);
    dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); checkOutput($sformatf("lw_mem%0d", i), obs, vMemLw);
    end
    dmem_ready = 1'b1;
    tick(); checkOutput("lw_wb", obs, vWbLw);
    tick(); checkOutput("lw_next_fetch", obs, vFetch);

    // sw: no WB
    applyStimulus(OP_SW, FN_ADD);
    tick(); checkOutput("sw_decode", obs, vIdle);
    tick(); checkOutput("sw_exec", obs, vExecAddr);
    tick(); checkOutput("sw_mem", obs, vMemSw);
    tick(); checkOutput("sw_next_fetch", obs, vFetch);

    // j: two cycles, jump target in DECODE
    applyStimulus(OP_J, FN_ADD);
    tick(); checkOutput("j_decode", obs, vJump);
    tick(); checkOutput("j_next_fetch", obs, vFetch);

    // fetch wait state holds the request without enables
    imem_ready = 1'b0;
    applyStimulus(OP_RTYPE, FN_ADD);
    tick(); checkOutput("fetch_wait", obs, vFetchWait);
    imem_ready = 1'b1;
    tick(); checkOutput("fetch_wait_decode", obs, vIdle);
    tick(); tick(); tick();
    checkOutput("add_back_fetch", obs, vFetch);

    // unknown opcode traps until reset
    applyStimulus(6'b111111, FN_ADD);
    tick(); checkOutput("badop_decode", obs, vIdle);
    for (int i = 0; i < 20; i++) begin
      tick(); checkOutput($sformatf("badop_trap%0d", i), obs, vTrap);
    end
    rst = 1'b1;
    tick(); checkOutput("trap_reset_fetch", obs, vFetch);
    rst = 1'b0;

    // unknown func under R-type opcode
    applyStimulus(OP_RTYPE, 4'b1111);
    tick(); checkOutput("badfunc_decode", obs, vIdle);
    tick(); checkOutput("badfunc_trap", obs, vTrap);
    start = 1'b1;
    tick(); checkOutput("badfunc_trap_start_ignored", obs, vTrap);
    start = 1'b0;
    rst = 1'b1;
    tick(); checkOutput("badfunc_reset_fetch", obs, vFetch);
    rst = 1'b0;

    // reset in the middle of a stalled store
    applyStimulus(OP_SW, FN_ADD);
    dmem_ready = 1'b0;
    tick(); tick();
    tick(); checkOutput("rstmem_mem", obs, vMemSw);
    tick(); checkOutput("rstmem_mem_hold", obs, vMemSw);
    rst = 1'b1; imem_ready = 1'b0;
    tick(); checkOutput("rstmem_fetch", obs, vFetchWait);
    rst = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;

    // HALT-after-reset instance waits for start
    tick(); checkOutput("halt_wait", obsH, vHalt);
    start = 1'b1;
    tick(); checkOutput("halt_start_fetch", obsH, vFetch);
    start = 1'b0;
    tick(); checkOutput("halt_then_decode", obsH, vIdle);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
